// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Iterative AES encryption controller. It owns the 128-bit state register and
// runs one round per clock through an external combinational round datapath.
// Round keys are fetched from the key store by index, and the key store
// answers in the same cycle.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   in_valid/in_ready plaintext handshake (plaintext: byte 0 at [127:120])
//   out_valid/out_ready ciphertext handshake (ciphertext held while stalled)
//   rk_idx / rk       round-key request / combinational key return
//   dp_state_o        state presented to the round datapath
//   dp_final_o        final round; the datapath skips MixColumns
//   dp_state_i        datapath result before AddRoundKey
//   busy              high while rounds are in progress
//
// state | meaning
// IDLE  | waiting for a plaintext block; rk_idx=0 selects the whitening key
// ROUND | one AES round per cycle; round counts 1..NR
// OUT   | ciphertext presented; waits for out_ready
module aes_round_sequencer #(
  parameter int NR        = 10,  // 10, 12 or 14
  parameter int DATA_SIZE = 128  // fixed at 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] plaintext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] ciphertext,
  output logic [3:0]           rk_idx,
  input  logic [DATA_SIZE-1:0] rk,
  output logic [DATA_SIZE-1:0] dp_state_o,
  output logic                 dp_final_o,
  input  logic [DATA_SIZE-1:0] dp_state_i,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t               state;
  logic [DATA_SIZE-1:0] state_reg;
  logic [3:0]           round;

  // Handshake and key-index flags are registered alongside the state, so
  // rk_idx always equals round while in ROUND and is 0 elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      state_reg  <= '0;
      round      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      rk_idx     <= '0;
      dp_final_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg  <= plaintext ^ rk;
            round      <= 4'd1;
            rk_idx     <= 4'd1;
            dp_final_o <= (NR_L == 4'd1);
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= dp_state_i ^ rk;
          if (round == NR_L) begin
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            rk_idx     <= '0;
            dp_final_o <= 1'b0;
            state      <= OUT;
          end else begin
            round      <= round + 4'd1;
            rk_idx     <= round + 4'd1;
            dp_final_o <= ((round + 4'd1) == NR_L);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            round     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wide buses are gated so the datapath sees zeros outside ROUND and the
  // consumer only ever sees a finished block.
  assign dp_state_o = busy      ? state_reg : '0;
  assign ciphertext = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  typedef logic [0:10][127:0] rks_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] dp_state_o;
  logic         dp_final_o;
  logic [127:0] dp_state_i;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [127:0] q_ct[$];
  int           q_cyc[$];
  rks_t         rk_all;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_round_sequencer #(.NR(10), .DATA_SIZE(128)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .plaintext(plaintext),
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext),
    .rk_idx(rk_idx), .rk(rk),
    .dp_state_o(dp_state_o), .dp_final_o(dp_final_o), .dp_state_i(dp_state_i),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference (FIPS-197, byte i at [127-8i]) ----------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 7; i >= 0; i--) begin   // b^254 = multiplicative inverse
      v = gmul(v, v);
      if (i != 0) v = gmul(v, b);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
      o[127 - 8*i -: 8] = sbox(s[127 - 8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic rks_t expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rks_t ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    rks_t ks;
    logic [127:0] s;
    ks = expand(key);
    s = pt ^ ks[0];
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r != 10) s = mix(s);
      s = s ^ ks[r];
    end
    return s;
  endfunction

  // Key store and round datapath models, both combinational.
  assign rk         = (rk_idx <= 4'd10) ? rk_all[rk_idx] : '0;
  assign dp_state_i = dp_final_o ? sub_shift(dp_state_o) : mix(sub_shift(dp_state_o));

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      q_ct.push_back(ciphertext);
      q_cyc.push_back(cyc);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One block through the DUT; returns with out_valid visible. With
  // out_ready=1 it also steps through the handoff back to IDLE.
  task automatic send_block(input string tag, input logic [127:0] pt, input logic [127:0] key);
    int n;
    rk_all    = expand(key);
    plaintext = pt;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd11);
    chk({tag, "_ct"}, ciphertext, aes_ref(pt, key));
    if (out_ready) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] key_r, pt_a, pt_b;
    logic [127:0] pts [0:2];
    int n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; plaintext = '0;
    rk_all = expand(128'h0);
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_in_ready",   128'(in_ready),   128'd1);
    chk("rst_out_valid",  128'(out_valid),  128'd0);
    chk("rst_busy",       128'(busy),       128'd0);
    chk("rst_ciphertext", ciphertext,       128'd0);
    chk("rst_rk_idx",     128'(rk_idx),     128'd0);
    chk("rst_dp_state",   dp_state_o,       128'd0);
    chk("rst_dp_final",   128'(dp_final_o), 128'd0);

    // FIPS-197 C.1 with round-by-round key index check
    rk_all = expand(FIPS_KEY);
    plaintext = FIPS_PT;
    in_valid = 1'b1;
    chk("fips_idle_rk_idx", 128'(rk_idx), 128'd0);
    step();
    in_valid = 1'b0;
    chk("fips_r1_dp_state", dp_state_o, FIPS_PT ^ rk_all[0]);
    for (int i = 1; i <= 10; i++) begin
      chk("fips_rk_idx",    128'(rk_idx),     128'(i));
      chk("fips_dp_final",  128'(dp_final_o), 128'(i == 10));
      chk("fips_busy",      128'(busy),       128'd1);
      chk("fips_in_ready",  128'(in_ready),   128'd0);
      chk("fips_out_valid", 128'(out_valid),  128'd0);
      step();
    end
    chk("fips_out_valid_at_11", 128'(out_valid), 128'd1);
    chk("fips_ct_const", ciphertext, FIPS_CT);
    chk("fips_out_rk_idx", 128'(rk_idx), 128'd0);
    chk("fips_out_dp_state", dp_state_o, 128'd0);
    step();
    chk("fips_handoff_valid", 128'(out_valid), 128'd0);
    chk("fips_handoff_ready", 128'(in_ready),  128'd1);

    // output backpressure with a random block
    key_r = {$urandom, $urandom, $urandom, $urandom};
    pt_a  = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send_block("bp", pt_a, key_r);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_ct_stable", ciphertext, aes_ref(pt_a, key_r));
      chk("bp_in_ready",  128'(in_ready),  128'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_ready", 128'(in_ready),  128'd1);

    // second block presented during ROUND is ignored until after handoff
    pt_b = {$urandom, $urandom, $urandom, $urandom};
    rk_all = expand(FIPS_KEY);
    plaintext = FIPS_PT;
    in_valid = 1'b1;
    step();
    plaintext = pt_b;
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("busy_ign_latency", 128'(n), 128'd11);
    chk("busy_ign_first_ct", ciphertext, FIPS_CT);
    step();
    chk("busy_ign_idle_ready", 128'(in_ready), 128'd1);
    chk("busy_ign_idle_busy",  128'(busy),     128'd0);
    step();
    in_valid = 1'b0;
    chk("busy_ign_second_accept", 128'(busy), 128'd1);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("busy_ign_second_latency", 128'(n), 128'd11);
    chk("busy_ign_second_ct", ciphertext, aes_ref(pt_b, FIPS_KEY));
    step();

    // reset at round 5
    plaintext = FIPS_PT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("midrst_round5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready",   128'(in_ready),  128'd1);
    chk("midrst_out_valid",  128'(out_valid), 128'd0);
    chk("midrst_busy",       128'(busy),      128'd0);
    chk("midrst_ciphertext", ciphertext,      128'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("midrst_no_output", 128'(n), 128'd0);
    send_block("midrst_fips", FIPS_PT, FIPS_KEY);

    // back-to-back blocks with in_valid held high
    key_r = {$urandom, $urandom, $urandom, $urandom};
    rk_all = expand(key_r);
    for (int b = 0; b < 3; b++) pts[b] = {$urandom, $urandom, $urandom, $urandom};
    q_ct.delete();
    q_cyc.delete();
    mon_en = 1'b1;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      plaintext = pts[b];
      n = 0;
      while (!in_ready && n < 40) begin
        step();
        n++;
      end
      chk("b2b_ready_seen", 128'(in_ready), 128'd1);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (q_ct.size() < 3 && n < 60) begin
      step();
      n++;
    end
    mon_en = 1'b0;
    chk("b2b_count", 128'(q_ct.size()), 128'd3);
    for (int b = 0; b < 3 && b < q_ct.size(); b++) begin
      chk("b2b_ct", q_ct[b], aes_ref(pts[b], key_r));
      if (b > 0) chk("b2b_spacing", 128'(q_cyc[b] - q_cyc[b-1]), 128'd12);
    end
    while (!in_ready && n < 80) begin
      step();
      n++;
    end

    // zero vector
    send_block("zero", 128'h0, 128'h0);
    vectors++;
    assert (aes_ref(128'h0, 128'h0) === ZERO_CT)
    else begin
      miscompares++;
      $error("FAIL zero_ref_const observed=%h expected=%h", aes_ref(128'h0, 128'h0), ZERO_CT);
    end

    // a few random blocks with random backpressure
    for (int k = 0; k < 3; k++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_a  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      send_block("rand", pt_a, key_r);
      repeat ($urandom_range(0, 4)) step();
      chk("rand_held_ct", ciphertext, aes_ref(pt_a, key_r));
      out_ready = 1'b1;
      step();
      chk("rand_release_ready", 128'(in_ready), 128'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
